// File: rtl/vga_mem_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of VGA position, display/render requester and memory-controller signals for vga_mem_arbiter.
// slave = arbiter view; master = requesters, timing generator and memory as seen from outside.
interface vga_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [9:0]    x;
  logic [9:0]    y;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          rend_req;
  logic          rend_we;
  logic [AW-1:0] rend_addr;
  logic [DW-1:0] rend_wdata;
  logic          rend_gnt;
  logic          rend_blocked;
  logic [DW-1:0] rdata;       // read data held for the requester, valid with its gnt
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  x, y, disp_req, disp_addr, rend_req, rend_we, rend_addr, rend_wdata,
           mem_ack, mem_rdata,
    output disp_gnt, rend_gnt, rend_blocked, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output x, y, disp_req, disp_addr, rend_req, rend_we, rend_addr, rend_wdata,
           mem_ack, mem_rdata,
    input  disp_gnt, rend_gnt, rend_blocked, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port memory between display prefetch (deadline) and render (aged best effort).
// Min 3 cycles req->gnt with a 1-cycle memory; mem_* held until mem_ack; ARB_STATS_EN adds frame stats.
module vga_mem_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int LOCK_X     = 620,
  parameter int STARVE_MAX = 64,
  parameter int AW         = 16,
  parameter int DW         = 16
) (
  input  logic              clk,
  input  logic              reset,
  vga_mem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_rend_cnt,
  output logic [7:0]        stat_disp_wait_max
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  if (LOCK_X >= H_TOTAL || H_ACTIVE > H_TOTAL) begin : g_bad_cfg
    $error("vga_mem_arbiter: LOCK_X and H_ACTIVE must lie inside the line");
  end

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_R} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          disp_gnt_q, disp_gnt_d;
  logic          rend_gnt_q, rend_gnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic disp_line, lockout, force_rend;

  // Lines whose successor is visible, so the prefetch for it runs at the line end.
  always_comb begin
    disp_line  = (bus.y < 10'(V_ACTIVE - 1)) || (bus.y == 10'(V_TOTAL - 1));
    lockout    = (bus.x >= 10'(LOCK_X)) && (bus.x < 10'(H_TOTAL)) && disp_line;
    force_rend = bus.rend_req && (starve_cnt_q >= SW'(STARVE_MAX)) && !lockout;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    disp_gnt_d   = 1'b0;
    rend_gnt_d   = 1'b0;
    rdata_d      = rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (force_rend || (!bus.disp_req && bus.rend_req && !lockout)) begin
          state_d     = BUSY_R;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.rend_we;
          mem_addr_d  = bus.rend_addr;
          mem_wdata_d = bus.rend_wdata;
        end else if (bus.disp_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.disp_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_D, BUSY_R: begin
        if (bus.mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          rdata_d    = bus.mem_rdata;
          disp_gnt_d = (state_q == BUSY_D);
          rend_gnt_d = (state_q == BUSY_R);
        end
      end
      default: state_d = IDLE;
    endcase

    // Cleared on the ack edge so a request re-raised in the gnt cycle is aged afresh.
    if (state_q == BUSY_R && bus.mem_ack)
      starve_cnt_d = '0;
    else if (bus.rend_req && state_q != BUSY_R && !lockout && starve_cnt_q < SW'(STARVE_MAX))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

`ifdef ARB_STATS_EN
  logic        origin_q, origin_d;
  logic [15:0] rend_cnt_q, rend_cnt_d, stat_rend_q, stat_rend_d;
  logic [7:0]  disp_wait_q, disp_wait_d, wait_max_q, wait_max_d, stat_wait_q, stat_wait_d;
  logic        origin, frame_start;

  always_comb begin
    origin      = (bus.x == 10'd0) && (bus.y == 10'd0);
    frame_start = origin && !origin_q;
    origin_d    = origin;
    rend_cnt_d  = (rend_gnt_q && rend_cnt_q != 16'hFFFF) ? rend_cnt_q + 16'd1 : rend_cnt_q;
    disp_wait_d = disp_wait_q;
    wait_max_d  = wait_max_q;
    stat_rend_d = stat_rend_q;
    stat_wait_d = stat_wait_q;
    if (state_q == IDLE && state_d == BUSY_D) begin
      if (disp_wait_q > wait_max_q) wait_max_d = disp_wait_q;
      disp_wait_d = '0;
    end else if (bus.disp_req && state_q != BUSY_D && disp_wait_q != 8'hFF) begin
      disp_wait_d = disp_wait_q + 8'd1;
    end
    if (frame_start) begin
      stat_rend_d = rend_cnt_d;
      stat_wait_d = wait_max_d;
      rend_cnt_d  = '0;
      wait_max_d  = '0;
    end
  end

  assign stat_rend_cnt      = stat_rend_q;
  assign stat_disp_wait_max = stat_wait_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_gnt_q   <= 1'b0;
      rend_gnt_q   <= 1'b0;
      rdata_q      <= '0;
      starve_cnt_q <= '0;
`ifdef ARB_STATS_EN
      origin_q     <= 1'b0;
      rend_cnt_q   <= '0;
      stat_rend_q  <= '0;
      disp_wait_q  <= '0;
      wait_max_q   <= '0;
      stat_wait_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_gnt_q   <= disp_gnt_d;
      rend_gnt_q   <= rend_gnt_d;
      rdata_q      <= rdata_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef ARB_STATS_EN
      origin_q     <= origin_d;
      rend_cnt_q   <= rend_cnt_d;
      stat_rend_q  <= stat_rend_d;
      disp_wait_q  <= disp_wait_d;
      wait_max_q   <= wait_max_d;
      stat_wait_q  <= stat_wait_d;
`endif
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.disp_gnt     = disp_gnt_q;
  assign bus.rend_gnt     = rend_gnt_q;
  assign bus.rdata        = rdata_q;
  assign bus.rend_blocked = lockout;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for vga_mem_arbiter: cycle-stepped memory model and requesters, scoreboard of expected memory accesses.
module tb_vga_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [DW-1:0] KEY = 16'h5A5A;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef ARB_STATS_EN
  logic [15:0] stat_rend_cnt;
  logic [7:0]  stat_disp_wait_max;
`endif

  vga_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_rend_cnt      (stat_rend_cnt),
    .stat_disp_wait_max (stat_disp_wait_max)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic sb_en = 1'b1;
  logic mem_hold = 1'b0;
  logic prev_mem_req = 1'b0;
  int   wait_cnt = 0;
  int   disp_todo = 0, rend_todo = 0;
  int   dseq = 0, rseq = 0;
  int   disp_done = 0, rend_done = 0;
  logic rend_abort = 1'b0;

  // One clock of environment: memory answers, scoreboard pops, requesters react to gnts.
  task automatic tick();
    txn_t e;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    if (bus.mem_req === 1'b1 && !mem_hold) begin
      if (wait_cnt == 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ KEY;
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
      end
    end else if (bus.mem_req !== 1'b1) begin
      wait_cnt = 0;
    end
    if (bus.mem_req === 1'b1 && !prev_mem_req && sb_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got addr=%h we=%b, want no access", bus.mem_addr, bus.mem_we);
      end else begin
        e = exp_q.pop_front();
        if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || (e.we && bus.mem_wdata !== e.wdata)) begin
          bad++;
          $display("FAIL sb_access: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.wdata);
        end
      end
    end
    prev_mem_req = (bus.mem_req === 1'b1);

    if (bus.disp_gnt === 1'b1) begin
      total++;
      if (bus.disp_req !== 1'b1 || bus.mem_req !== 1'b0 || bus.rdata !== (bus.disp_addr ^ KEY)) begin
        bad++;
        $display("FAIL disp_gnt: got req=%b mem_req=%b rdata=%h, want 1 0 %h",
                 bus.disp_req, bus.mem_req, bus.rdata, bus.disp_addr ^ KEY);
      end
      disp_done++;
      bus.disp_req = 1'b0;
    end
    if (!bus.disp_req && disp_todo > 0) begin
      bus.disp_addr = 16'h1000 + 16'(dseq);
      bus.disp_req  = 1'b1;
      dseq++;
      disp_todo--;
    end

    if (rend_abort) begin
      bus.rend_req = 1'b0;
      rend_todo    = 0;
    end
    if (bus.rend_gnt === 1'b1) begin
      total++;
      if (bus.rend_req !== 1'b1 || bus.mem_req !== 1'b0 ||
          (!bus.rend_we && bus.rdata !== (bus.rend_addr ^ KEY))) begin
        bad++;
        $display("FAIL rend_gnt: got req=%b mem_req=%b rdata=%h, want 1 0 %h",
                 bus.rend_req, bus.mem_req, bus.rdata, bus.rend_addr ^ KEY);
      end
      rend_done++;
      bus.rend_req = 1'b0;
    end
    if (!bus.rend_req && rend_todo > 0 && !rend_abort) begin
      bus.rend_addr  = 16'h8000 + 16'(rseq);
      bus.rend_we    = rseq[0];
      bus.rend_wdata = ~(16'h8000 + 16'(rseq));
      bus.rend_req   = 1'b1;
      rseq++;
      rend_todo--;
    end
  endtask

  task automatic push_disp(input int n);
    txn_t e;
    for (int i = 0; i < n; i++) begin
      e.we = 1'b0; e.addr = 16'h1000 + 16'(dseq + i); e.wdata = '0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_rend(input int n);
    txn_t e;
    int   r;
    for (int i = 0; i < n; i++) begin
      r = rseq + i;
      e.we = r[0]; e.addr = 16'h8000 + 16'(r); e.wdata = ~(16'h8000 + 16'(r));
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus.x = 10'd0; bus.y = 10'd500;
    push_disp(1); push_rend(1);
    disp_todo = 1; rend_todo = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b0 || bus.disp_gnt !== 1'b0 || bus.rend_gnt !== 1'b0 ||
          bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
        bad++;
        $display("FAIL reset_vals: got req=%b dg=%b rg=%b we=%b addr=%h wd=%h, want all 0",
                 bus.mem_req, bus.disp_gnt, bus.rend_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h1000) begin
      bad++;
      $display("FAIL reset_first_req: got req=%b we=%b addr=%h, want 1 0 1000",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    for (int i = 0; i < 30 && !(disp_done == 1 && rend_done == 1); i++) tick();
    total++;
    if (disp_done != 1 || rend_done != 1) begin
      bad++;
      $display("FAIL reset_drain: got disp_done=%0d rend_done=%0d, want 1 1", disp_done, rend_done);
    end
  endtask

  task automatic test_simultaneous();
    bus.y = 10'd500;
    push_disp(1); push_rend(1);
    disp_todo = 1; rend_todo = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (bus.disp_gnt !== (k == 4) || bus.rend_gnt !== (k == 7)) begin
        bad++;
        $display("FAIL simul_gnt_k%0d: got dg=%b rg=%b, want %b %b",
                 k, bus.disp_gnt, bus.rend_gnt, (k == 4), (k == 7));
      end
    end
  endtask

  task automatic test_lockout_map();
    int tx[10] = '{619, 620, 799, 0,   700, 700, 700, 700, 700, 639};
    int ty[10] = '{100, 100, 100, 100, 478, 479, 480, 523, 524, 0};
    logic te[10] = '{0, 1, 1, 0, 1, 0, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      bus.x = 10'(tx[i]); bus.y = 10'(ty[i]);
      #1;
      total++;
      if (bus.rend_blocked !== te[i]) begin
        bad++;
        $display("FAIL lockout_map x=%0d y=%0d: got %b, want %b", tx[i], ty[i], bus.rend_blocked, te[i]);
      end
    end
  endtask

  task automatic test_lockout();
    int done0 = rend_done;
    bus.y = 10'd100;
    push_rend(1);
    rend_todo = 1;
    for (int xi = 620; xi <= 799; xi++) begin
      bus.x = 10'(xi);
      tick();
      total++;
      if (bus.rend_blocked !== 1'b1 || bus.mem_req !== 1'b0 || bus.rend_gnt !== 1'b0) begin
        bad++;
        $display("FAIL lockout_x%0d: got blk=%b mem_req=%b rg=%b, want 1 0 0",
                 xi, bus.rend_blocked, bus.mem_req, bus.rend_gnt);
      end
    end
    bus.x = 10'd0;
    for (int i = 0; i < 10 && rend_done == done0; i++) tick();
    total++;
    if (rend_done != done0 + 1 || bus.rend_blocked !== 1'b0) begin
      bad++;
      $display("FAIL lockout_release: got grants=%0d blk=%b, want 1 0", rend_done - done0, bus.rend_blocked);
    end
  endtask

  task automatic test_vblank();
    int done0 = rend_done;
    bus.y = 10'd500;
    push_rend(3);
    rend_todo = 3;
    for (int i = 0; i < 40 && rend_done < done0 + 3; i++) begin
      bus.x = 10'((600 + 10 * i) % 800);
      tick();
      total++;
      if (bus.rend_blocked !== 1'b0) begin
        bad++;
        $display("FAIL vblank_blk x=%0d: got %b, want 0", bus.x, bus.rend_blocked);
      end
    end
    total++;
    if (rend_done != done0 + 3) begin
      bad++;
      $display("FAIL vblank_grants: got %0d, want 3", rend_done - done0);
    end
  endtask

  task automatic test_starvation();
    int t1 = 0, t2 = 0, td = 0, dbefore = 0, r0, d0;
    sb_en = 1'b0;
    bus.x = 10'd0; bus.y = 10'd10;
    disp_todo = 100;
    for (int i = 0; i < 6; i++) tick();
    r0 = rend_done; d0 = disp_done;
    rend_todo = 2;
    for (int t = 1; t <= 200 && t2 == 0; t++) begin
      tick();
      if (rend_done == r0 + 1 && t1 == 0) begin t1 = t; dbefore = disp_done - d0; d0 = disp_done; end
      if (t1 != 0 && td == 0 && disp_done > d0) td = t;
      if (rend_done == r0 + 2) t2 = t;
    end
    total++;
    if (t1 < 65 || t1 > 72) begin
      bad++;
      $display("FAIL starve_first: got %0d cycles, want 65..72", t1);
    end
    total++;
    if (dbefore < 20) begin
      bad++;
      $display("FAIL starve_disp_before: got %0d grants, want >=20", dbefore);
    end
    total++;
    if (td - t1 < 1 || td - t1 > 4) begin
      bad++;
      $display("FAIL starve_disp_resume: got %0d cycles, want 1..4", td - t1);
    end
    total++;
    if (t2 - t1 < 65 || t2 - t1 > 72) begin
      bad++;
      $display("FAIL starve_cleared: got %0d cycles, want 65..72", t2 - t1);
    end
    disp_todo = 0;
    for (int i = 0; i < 20 && (bus.disp_req || bus.rend_req || bus.mem_req !== 1'b0); i++) tick();
    tick(); tick();
    exp_q.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int done0 = rend_done;
    bus.y = 10'd500;
    push_rend(1);
    mem_hold = 1'b1;
    rend_todo = 1;
    for (int i = 0; i < 10 && bus.mem_req !== 1'b1; i++) tick();
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_start: got mem_req=%b, want 1", bus.mem_req);
    end
    tick();
    reset = 1'b1; rend_abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.mem_req !== 1'b0 || bus.rend_gnt !== 1'b0 || rend_done != done0) begin
        bad++;
        $display("FAIL rmid_drop_%0d: got mem_req=%b rg=%b, want 0 0", i, bus.mem_req, bus.rend_gnt);
      end
    end
    reset = 1'b0; rend_abort = 1'b0; mem_hold = 1'b0;
    tick(); tick();
    total++;
    if (bus.mem_req !== 1'b0 || bus.rend_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after: got mem_req=%b rg=%b, want 0 0", bus.mem_req, bus.rend_gnt);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    int done0;
    bus.x = 10'd0; bus.y = 10'd0; tick();
    bus.x = 10'd1; tick();
    bus.y = 10'd500;
    done0 = rend_done;
    push_rend(3);
    rend_todo = 3;
    for (int i = 0; i < 40 && rend_done < done0 + 3; i++) tick();
    tick();
    bus.x = 10'd0; bus.y = 10'd0; tick();
    bus.x = 10'd1; tick();
    total++;
    if (stat_rend_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stat_rend_cnt: got %0d, want 3", stat_rend_cnt);
    end
  endtask
`endif

  initial begin
    bus.x = '0; bus.y = '0;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.rend_req = 1'b0; bus.rend_we = 1'b0; bus.rend_addr = '0; bus.rend_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    test_reset();
    tick(); tick();
    test_simultaneous();
    tick(); tick();
    test_lockout_map();
    test_lockout();
    tick(); tick();
    test_vblank();
    tick(); tick();
    test_starvation();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Arbitrates one shared single-port memory between two requesters: the display line-prefetch engine (hard deadline) and the render engine (best effort).
- Sits between the vga timing generator, the line buffer fetcher, the rasterizer and the external memory controller.
- Uses the vga x/y counters to lock the render engine out ahead of the display prefetch window.
- Ages the render request so it cannot starve indefinitely.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- LOCK_X, 620, first x of the render lockout window on display lines
- STARVE_MAX, 64, clk cycles a pending render request waits before it is forced ahead of display
- AW, 16, memory address width
- DW, 16, memory data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  10  current vga pixel x
- y  in  10  current vga line y
- disp_req  in  1  display read request; held until disp_gnt
- disp_addr  in  AW  display read address; stable while disp_req is high
- disp_gnt  out  1  one-cycle pulse: display read done, mem_rdata valid
- rend_req  in  1  render request; held until rend_gnt
- rend_we  in  1  1 = write, 0 = read
- rend_addr  in  AW  render address
- rend_wdata  in  DW  render write data
- rend_gnt  out  1  one-cycle pulse: render access done
- rend_blocked  out  1  lockout window is active (combinational from x/y)
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  one-cycle completion pulse from memory; read data valid in the same cycle
- mem_rdata  in  DW  memory read data, passed through to both requesters

Behaviour:
- Reset values: mem_req, mem_we, disp_gnt and rend_gnt are 0; mem_addr and mem_wdata are 0; state is IDLE; starve_cnt is 0.
- Reset asserted mid-transaction drops mem_req on the next edge. The memory side shares the same reset.
- States: IDLE, BUSY_D, BUSY_R.
- Display line set: y < V_ACTIVE-1 or y == V_TOTAL-1. These are the lines whose next line is visible.
- lockout = (x >= LOCK_X) and display line.
- rend_blocked = lockout.
- force = rend_req and (starve_cnt >= STARVE_MAX) and not lockout.
- IDLE priority, evaluated each cycle:
  1. force: go to BUSY_R.
  2. Else disp_req: go to BUSY_D.
  3. Else rend_req and not lockout: go to BUSY_R.
  4. Else stay in IDLE.
- Entering a BUSY state registers the selected requester's address, data and write enable onto mem_* and sets mem_req = 1 on the same edge. Display accesses always drive mem_we = 0.
- In a BUSY state, mem_* outputs are frozen until mem_ack.
- On mem_ack:
  - Pulse the matching gnt for exactly one cycle, in the cycle after the ack.
  - mem_rdata is passed through and is valid in the ack cycle. The requester samples it with gnt, so the arbiter registers mem_rdata into an internal hold register that drives the requester-facing data.
  - mem_req returns to 0 and the state returns to IDLE.
- Timing consequences:
  - There is at least one IDLE cycle between transactions.
  - Minimum request-to-gnt latency is 3 cycles when memory acks 1 cycle after mem_req.
- mem_ack while in IDLE is ignored. mem_ack in the same cycle that mem_req rises is impossible by the memory contract.
- A transaction already in flight is never aborted when lockout begins. LOCK_X must leave margin for the worst-case memory latency.
- starve_cnt:
  - Increments each cycle that rend_req = 1 and no render access is in flight.
  - Saturates at STARVE_MAX.
  - Clears on rend_gnt.
  - Does not increment while lockout is active.
- Simultaneous disp_req and rend_req with starve_cnt < STARVE_MAX: display wins.
- A requester dropping its req before gnt is a protocol violation; behaviour is undefined.
- x/y wrap (799 to 0, 524 to 0) needs no special handling; lockout is purely combinational from x/y.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, two extra outputs are added:
  - stat_rend_cnt [15:0]: render grants in the last frame. It is latched, and the running count cleared, on the first clk cycle where x == 0 and y == 0.
  - stat_disp_wait_max [7:0]: the largest number of cycles disp_req was high before its BUSY_D entry. It saturates at 255, is latched at the same frame boundary, and is then cleared.
- When undefined: no ports, no counters, no logic.

Test Plan:
- Reset: hold reset 2 cycles with both reqs high -> mem_req=0, gnts=0. First mem_req asserts 1 cycle after release, for display.
- Simultaneous requests: disp_req and rend_req together, memory acks 1 cycle after req -> disp_gnt first, then rend_gnt. Each gnt is one cycle wide and an IDLE cycle separates the two transactions.
- Lockout: y=100, x=620..799, rend_req only -> no render grant and rend_blocked=1. Render grant follows once x wraps to 0.
- Vblank: y=500, any x, rend_req held -> render grants each transaction; rend_blocked=0.
- Starvation: disp_req continuously back-to-back and rend_req at y=10, x=0 -> render forced after 64 waiting cycles. starve_cnt clears on rend_gnt, and display resumes.
- Reset mid-transaction: reset asserted in BUSY_R with no ack -> mem_req=0 next cycle, no gnt pulse. ARB_STATS_EN build: one frame with 3 render grants -> stat_rend_cnt=3 at x=0, y=0.
